// File: rtl/hash_pkg.sv
// Shared types and constants for the hash result scanner.
package hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_WR0  = 3'd2,
    ST_WR1  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int          RESULT_FOUND_BIT = 31;
  localparam logic [31:0] HASH_INIT_MAX    = 32'hFFFF_FFFF;
  localparam logic [15:0] RES_OFS_STATUS   = 16'd0;
  localparam logic [15:0] RES_OFS_HASH     = 16'd1;

endpackage

// File: rtl/hash_target_scan.sv
// Reads back per-nonce hash words, tracks the minimum against a target and
// writes a two-word {status, hash} result record to the shared memory.
module hash_target_scan
  import hash_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int NW         = $clog2(NUM_NONCES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   hash_addr,
  input  logic [15:0]   result_addr,
  input  logic [31:0]   target,
  output logic          done,
  output logic          mem_clk,
  output logic          mem_we,
  output logic [15:0]   mem_addr,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data,
  output logic          found,
  output logic [NW-1:0] best_nonce,
  output logic [31:0]   best_hash
);

  localparam int CW = NW + 1;

  state_t          r_state;
  logic [CW-1:0]   r_issue_cnt;
  logic [NW-1:0]   r_cap_cnt;
  logic            r_primed;
  logic            r_done;
  logic            r_mem_we;
  logic [15:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic            r_found;
  logic [NW-1:0]   r_best_nonce;
  logic [31:0]     r_best_hash;

  logic            w_hit;
  logic [31:0]     w_new_best;
  logic [31:0]     w_status;

  // Strict compare keeps the lower index on ties.
  always_comb begin
    w_hit                      = (mem_read_data < r_best_hash);
    w_new_best                 = w_hit ? mem_read_data : r_best_hash;
    w_status                   = 32'd0;
    w_status[NW-1:0]           = r_best_nonce;
    w_status[RESULT_FOUND_BIT] = r_found;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_issue_cnt  <= '0;
      r_cap_cnt    <= '0;
      r_primed     <= 1'b0;
      r_done       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 16'd0;
      r_mem_wdata  <= 32'd0;
      r_found      <= 1'b0;
      r_best_nonce <= '0;
      r_best_hash  <= HASH_INIT_MAX;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_SCAN;
            r_mem_addr   <= hash_addr;
            r_issue_cnt  <= CW'(1);
            r_cap_cnt    <= '0;
            r_primed     <= 1'b0;
            r_best_hash  <= HASH_INIT_MAX;
            r_best_nonce <= '0;
            r_found      <= 1'b0;
            r_done       <= 1'b0;
            r_mem_we     <= 1'b0;
          end else if (r_state == ST_DONE) begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (r_issue_cnt < CW'(NUM_NONCES)) begin
            r_mem_addr  <= hash_addr + 16'(r_issue_cnt);
            r_issue_cnt <= r_issue_cnt + CW'(1);
          end
          // First SCAN edge has no read data yet; capture starts one edge later.
          if (r_primed) begin
            if (w_hit) begin
              r_best_hash  <= mem_read_data;
              r_best_nonce <= r_cap_cnt;
            end
            r_found   <= (w_new_best < target);
            r_cap_cnt <= r_cap_cnt + NW'(1);
            if (r_cap_cnt == NW'(NUM_NONCES - 1)) begin
              r_state <= ST_WR0;
            end
          end else begin
            r_primed <= 1'b1;
          end
        end
        ST_WR0: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= result_addr + RES_OFS_STATUS;
          r_mem_wdata <= w_status;
          r_state     <= ST_WR1;
        end
        ST_WR1: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= result_addr + RES_OFS_HASH;
          r_mem_wdata <= r_best_hash;
          r_state     <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign done           = r_done;
  assign mem_clk        = clk;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign found          = r_found;
  assign best_nonce     = r_best_nonce;
  assign best_hash      = r_best_hash;

endmodule

// File: doc/hash_target_scan.md
# hash_target_scan

Downstream consumer of the nonce-sweep hash engine. After the engine has written one 32-bit final-hash word per nonce into shared memory, this block reads those words back, compares each one against a 32-bit difficulty target, and tracks the minimum hash and its nonce. It then writes a two-word result record to memory and raises `done`. It shares the same single-port synchronous memory interface as the hash engine.

## Interface
- `NUM_NONCES`, default 16: number of consecutive hash words to scan. Legal range 2..256.
- `NW`, default `$clog2(NUM_NONCES)`: nonce index width (4 at the default).
- `clk` input 1: sole clock; also drives `mem_clk`.
- `reset` input 1: synchronous, active-high.
- `start` input 1: sampled only in IDLE and DONE.
- `hash_addr` input 16: base address of hash word for nonce 0.
- `result_addr` input 16: base address of the 2-word result record.
- `target` input 32: unsigned difficulty target; must be stable from `start` until `done`.
- `done` output 1: high in DONE.
- `mem_clk` output 1: equals `clk`.
- `mem_we` output 1: memory write enable (registered).
- `mem_addr` output 16: memory address (registered).
- `mem_write_data` output 32: write data (registered).
- `mem_read_data` input 32: read data for the address registered on the previous edge.
- `found` output 1: best hash is strictly below `target`.
- `best_nonce` output NW: index of the minimum hash.
- `best_hash` output 32: minimum hash value.

## Operation
- States: IDLE, SCAN, WR0, WR1, DONE.
- **Reset values:** state IDLE; `done`, `mem_we`, `mem_addr`, `mem_write_data`, `found`, `best_nonce` all 0; `best_hash` 32'hFFFFFFFF.
- **IDLE, `start`=1:**
  - `mem_addr` <= `hash_addr`, issue count 1, capture count 0.
  - `best_hash` <= FFFFFFFF, `best_nonce` <= 0, `found` <= 0.
  - Go to SCAN.
- **SCAN, issue side:** while issue count < NUM_NONCES, `mem_addr` <= `hash_addr` + issue count, and issue count increments.
- **SCAN, capture side:** from the second SCAN edge onward, each edge captures `mem_read_data` as word i.
  - If word i < `best_hash` (strict, unsigned): update `best_hash` and `best_nonce` = i. Ties keep the lower index.
  - At capture of i = NUM_NONCES-1, go to WR0.
- **`found` update:** registered on every capture as (updated best) < `target`. Consequences:
  - `target` = 0 never sets `found`.
  - A hash equal to `target` does not set `found`.
- **WR0:** `mem_we` <= 1, `mem_addr` <= `result_addr`, `mem_write_data` <= {`found`, zero fill, `best_nonce`}. Bit 31 = found, low NW bits = nonce. Go to WR1.
- **WR1:** `mem_addr` <= `result_addr`+1, `mem_write_data` <= `best_hash`, `mem_we` stays 1. Go to DONE.
- **DONE:** `mem_we` <= 0, `done` <= 1. The result outputs hold.
  - `start` in DONE behaves as in IDLE and clears `done` on the same edge.
- `start` in SCAN, WR0 or WR1 is ignored.
- **Address arithmetic:** 16-bit, wraps modulo 2^16.
- **Reset mid-operation:** next edge returns all registers to their reset values, so `mem_we` = 0 and no further writes occur. A partially written record is not repaired.

## Timing
- **Memory latency:** an address registered at edge k is sampled by memory at edge k+1. Its data is captured by this block at edge k+2.
- **Edge sequence:** let E0 be the edge at which `start` is sampled in IDLE.
  - Word i is captured at E(i+2).
  - WR0 is entered at E(NUM_NONCES+1).
  - Record word 0 is on the bus after E(NUM_NONCES+2).
  - Record word 1 is on the bus after E(NUM_NONCES+3).
  - `done` = 1 after E(NUM_NONCES+4): 20 cycles at the default.
- **Writes:** `mem_we` is high for exactly 2 consecutive cycles per run.
- **Read/write separation:** no read is issued while `mem_we` = 1.
- **Result port stability:** `found`, `best_nonce` and `best_hash` are stable from WR0 until the next `start`.

## Structure
- **Shared package `hash_pkg`:**
  - state enum type.
  - `RESULT_FOUND_BIT` = 31.
  - `HASH_INIT_MAX` = 32'hFFFFFFFF.
  - result record word offsets (0 = status, 1 = hash).
- **Sub-modules:** none. The comparator and min-tracker are a few lines and stay inline. One FSM and one always block with synchronous reset.

## Test plan
- **Strictly increasing hashes:** memory at `hash_addr`=0x0100 holds 0x10+i for i=0..15; `target`=0x11. Expect:
  - record {0x80000000, 0x00000010}, `best_nonce`=0, `found`=1.
  - `done` exactly 20 cycles after `start`.
- **Single small hash:** all words 0xFFFFFFF0 except word 9 = 0x00000005; `target`=0x00000005. Expect `found`=0 (equality is not a hit), `best_nonce`=9, record {0x00000009, 0x00000005}.
- **Tie and zero target:** words 3 and 12 both 0x0000ABCD, all others larger; `target`=0. Expect `best_nonce`=3, `found`=0.
- **Address wrap and writes:** `hash_addr`=0xFFF8 (wraps to 0x0007), `result_addr`=0x0200. Check the read addresses wrap, and `mem_we` is high for exactly 2 cycles, at 0x0200 then 0x0201.
- **Reset and start handling:**
  - Assert `reset` at capture 7. Expect IDLE, `mem_we`=0, `best_hash`=FFFFFFFF on the next edge, and no writes.
  - Then `start` again and expect a correct full run.
  - `start` pulsed mid-SCAN is ignored.
  - `start` in DONE reruns and drops `done`.
